soc_system_button_pio: RTL

Avalon-MM slave input port that samples external push-buttons/switches, synchronizes and debounces each bit, latches edges into a sticky capture register and raises a maskable level interrupt to the HPS. It is the read-side counterpart of the LED output PIO on the same lightweight HPS-to-FPGA bridge, and uses the same 2-bit word address and 32-bit zero-wait-state register map.

---
 rtl/soc_system_button_pio.sv | 110 +++++++++++
 1 files changed

// File: rtl/soc_system_button_pio.sv
// Avalon-MM input PIO: synchronizes and debounces push-buttons, latches edges into
// a write-1-to-clear capture register and drives a maskable level interrupt.
module soc_system_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic             wr_en;
    logic             mask_we;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign mask_we      = wr_en && (address == 2'd1);
    assign clr          = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // A level is accepted on the cycle the counter is already at terminal count
    // and the synchronized input still disagrees; any agreement restarts from 0.
    always_comb begin
        deb_next = deb;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != deb[i]) begin
                if (cnt[i] == TERM) begin
                    deb_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise = deb_next & ~deb;
    assign fall = ~deb_next & deb;

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_det = fall;
        end else begin
            edge_det = rise | fall;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            deb  <= '0;
            mask <= '0;
            cap  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1  <= in_port;
            s2  <= s1;
            deb <= deb_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (mask_we) begin
                mask <= writedata[WIDTH-1:0];
            end
            // A newly detected edge wins over a simultaneous W1C clear.
            cap <= edge_det | (cap & ~clr);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = deb;
            2'd1:    readdata[WIDTH-1:0] = mask;
            2'd3:    readdata[WIDTH-1:0] = cap;
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap & mask);

endmodule
